// File: rtl/uart_comm_pkg.sv
// uart_comm_pkg: message constants, parser states and the response byte ROM
package uart_comm_pkg;
  localparam logic [7:0] MSG_INFO_REQ = 8'h00;
  localparam logic [7:0] MSG_INVALID = 8'h01;
  localparam logic [7:0] MSG_PUSH_JOB = 8'h02;
  localparam logic [7:0] MSG_NONCE = 8'h03;
  localparam logic [7:0] MSG_ACK = 8'h04;
  localparam logic [7:0] PONG = 8'h01;
  localparam logic [7:0] MIN_LEN = 8'd8;
  localparam logic [7:0] MAX_LEN = 8'd60;
  localparam logic [95:0] INFO_PAYLOAD = 96'hDEADBEEF_13370D13_00000000;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISPATCH} parse_state_t;
  typedef enum logic [2:0] {RSP_PONG, RSP_INFO, RSP_INVALID, RSP_ACK, RSP_NONCE} rsp_t;
  function automatic logic [3:0] rsp_last(rsp_t k);
    return k == RSP_PONG ? 4'd0 : k == RSP_INFO ? 4'd15 : 4'd7;
  endfunction
  // Whole response laid out MSB-first, so byte i is the top byte after shifting by i bytes
  function automatic logic [7:0] rsp_byte(rsp_t k, logic [3:0] i, logic [31:0] n);
    logic [127:0] m;
    m = k == RSP_PONG ? {PONG, 120'h0} :
        k == RSP_INFO ? {8'h10, 24'h0, INFO_PAYLOAD} :
        {8'h08, 16'h0, k == RSP_ACK ? MSG_ACK : k == RSP_NONCE ? MSG_NONCE : MSG_INVALID,
         k == RSP_NONCE ? n : 32'h0, 64'h0};
    m = m << {i, 3'b000};
    return m[127:120];
  endfunction
endpackage

// File: rtl/uart_comm_serdes.sv
// uart_serdes: 8N1 byte receiver and back-to-back byte transmitter
module uart_serdes #(
  parameter int CPB = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial
);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  logic [2:0] rx_sync;
  logic rx_busy, tx_busy;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_bit, tx_bit;
  logic [7:0] rx_sh;
  logic [8:0] tx_sh;
  always_ff @(posedge clk)
    if (rst) begin
      rx_sync <= 3'b111;
      rx_busy <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], rx_serial};
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_sync[2] && !rx_sync[1]) begin
          rx_busy <= 1'b1;
          rx_cnt <= HALF;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
      else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) rx_busy <= !rx_sync[1];
        else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_valid <= rx_sync[1];
          rx_data <= rx_sh;
        end else rx_sh <= {rx_sync[1], rx_sh[7:1]};
      end
    end
  // Ready in the last cycle of the stop bit so the next byte follows with no idle gap
  assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == '0);
  always_ff @(posedge clk)
    if (rst) begin
      tx_busy <= 1'b0;
      tx_serial <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '1;
    end else if (tx_valid && tx_ready) begin
      tx_busy <= 1'b1;
      tx_serial <= 1'b0;
      tx_sh <= {1'b1, tx_data};
      tx_cnt <= FULL;
      tx_bit <= '0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
      else if (tx_bit == 4'd9) tx_busy <= 1'b0;
      else begin
        tx_serial <= tx_sh[0];
        tx_sh <= {1'b1, tx_sh[8:1]};
        tx_bit <= tx_bit + 4'd1;
        tx_cnt <= FULL;
      end
    end
endmodule

// File: rtl/uart_comm.sv
// uart_comm: host command parser, job registers and response/nonce arbitration
module uart_comm
  import uart_comm_pkg::*;
#(
  parameter int baud_rate = 115200,
  parameter int sys_clk_freq = 100000000
) (
  input  logic         comm_clk,
  input  logic         reset,
  input  logic         rx_serial,
  output logic         tx_serial,
  input  logic         new_golden_nonce,
  input  logic [31:0]  golden_nonce,
  output logic         new_work,
  output logic [95:0]  work_data,
  output logic [31:0]  nonce_min,
  output logic [31:0]  nonce_max,
  output logic [255:0] midstate
);
  localparam int CPB = sys_clk_freq / baud_rate;
  logic [7:0] rx_data, tx_data, len, typ;
  logic rx_valid, tx_valid, tx_ready, tx_fire, tx_start;
  logic cmd_pend, nonce_pend, nonce_prev, snd_active;
  logic [5:0] cnt;
  logic [3:0] snd_idx;
  logic [31:0] nonce_val, snd_nonce;
  logic [447:0] payload, payload_next;
  parse_state_t state;
  rsp_t disp_kind, cmd_kind, snd_kind, cur_kind;
  uart_serdes #(.CPB(CPB)) u_serdes (
    .clk(comm_clk), .rst(reset), .rx_serial(rx_serial), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_serial(tx_serial)
  );
  // Payload bytes 4..L-1 shift in from the top; for a full job byte k ends at bit (k-4)*8
  assign payload_next = {rx_data, payload[447:8]};
  always_ff @(posedge comm_clk)
    if (reset) begin
      state <= IDLE;
      len <= '0;
      typ <= '0;
      cnt <= '0;
      disp_kind <= RSP_PONG;
      payload <= '0;
      new_work <= 1'b0;
      work_data <= '0;
      nonce_min <= '0;
      nonce_max <= '0;
      midstate <= '0;
    end else begin
      new_work <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          len <= rx_data;
          cnt <= 6'd1;
          disp_kind <= rx_data == 8'd0 ? RSP_PONG : RSP_INVALID;
          state <= (rx_data < MIN_LEN || rx_data > MAX_LEN) ? DISPATCH : HDR;
        end
        HDR: if (rx_valid) begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd3) begin
            typ <= rx_data;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: if (rx_valid) begin
          cnt <= cnt + 6'd1;
          payload <= payload_next;
          if ({2'b00, cnt} == len - 8'd1) begin
            state <= DISPATCH;
            disp_kind <= (typ == MSG_INFO_REQ && len == MIN_LEN) ? RSP_INFO :
                         (typ == MSG_PUSH_JOB && len == MAX_LEN) ? RSP_ACK : RSP_INVALID;
            if (typ == MSG_PUSH_JOB && len == MAX_LEN) begin
              new_work <= 1'b1;
              nonce_max <= payload_next[63:32];
              nonce_min <= payload_next[95:64];
              work_data <= payload_next[191:96];
              midstate <= payload_next[447:192];
            end
          end
        end
        DISPATCH: if (!cmd_pend) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign tx_valid = snd_active || cmd_pend || nonce_pend;
  assign cur_kind = snd_active ? snd_kind : cmd_pend ? cmd_kind : RSP_NONCE;
  assign tx_data = rsp_byte(cur_kind, snd_active ? snd_idx : 4'd0, snd_active ? snd_nonce : nonce_val);
  assign tx_fire = tx_valid && tx_ready;
  assign tx_start = tx_fire && !snd_active;
  // Not reset, so a nonce level held across reset is not reported again
  always_ff @(posedge comm_clk) nonce_prev <= new_golden_nonce;
  always_ff @(posedge comm_clk)
    if (reset) begin
      cmd_pend <= 1'b0;
      cmd_kind <= RSP_PONG;
      nonce_pend <= 1'b0;
      nonce_val <= '0;
      snd_active <= 1'b0;
      snd_kind <= RSP_PONG;
      snd_idx <= '0;
      snd_nonce <= '0;
    end else begin
      if (state == DISPATCH && !cmd_pend) begin
        cmd_pend <= 1'b1;
        cmd_kind <= disp_kind;
      end else if (tx_start && cmd_pend) cmd_pend <= 1'b0;
      if (new_golden_nonce && !nonce_prev) begin
        nonce_pend <= 1'b1;
        nonce_val <= golden_nonce;
      end else if (tx_start && !cmd_pend) nonce_pend <= 1'b0;
      if (tx_start) begin
        snd_active <= cur_kind != RSP_PONG;
        snd_kind <= cur_kind;
        snd_idx <= 4'd1;
        snd_nonce <= nonce_val;
      end else if (tx_fire) begin
        snd_idx <= snd_idx + 4'd1;
        if (snd_idx == rsp_last(snd_kind)) snd_active <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_comm.sv
// tb_uart_comm: randomized frame-level bench against a spec-level response/job model
module tb_uart_comm;
  logic clk = 1'b0, reset = 1'b1, rx_serial = 1'b1, new_golden_nonce = 1'b0;
  logic [31:0] golden_nonce = '0;
  logic tx_serial, new_work;
  logic [95:0] work_data;
  logic [31:0] nonce_min, nonce_max;
  logic [255:0] midstate;
  int checks = 0, failures = 0, cyc = 0, stop_cyc = 0, ref_cyc = 0, nw_cnt = 0, e_nw = 0, mon_t;
  logic [7:0] frm[$], exp_q[$], got_q[$];
  int got_t[$];
  logic [7:0] mon_b;
  bit mon_en = 1'b0;
  logic [31:0] e_nmax = '0, e_nmin = '0, s_nmax = '0, s_nmin = '0;
  logic [95:0] e_work = '0, s_work = '0;
  logic [255:0] e_mid = '0, s_mid = '0;

  uart_comm #(.baud_rate(1), .sys_clk_freq(16)) dut (
    .comm_clk(clk), .reset(reset), .rx_serial(rx_serial), .tx_serial(tx_serial),
    .new_golden_nonce(new_golden_nonce), .golden_nonce(golden_nonce), .new_work(new_work),
    .work_data(work_data), .nonce_min(nonce_min), .nonce_max(nonce_max), .midstate(midstate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      s_nmax = '0; s_nmin = '0; s_work = '0; s_mid = '0;
    end else if (new_work === 1'b1) begin
      nw_cnt++;
      s_nmax = nonce_max; s_nmin = nonce_min; s_work = work_data; s_mid = midstate;
    end

  // Serial receiver for the DUT's transmit line, sampling each bit at its centre
  initial forever begin
    @(negedge clk);
    if (mon_en && tx_serial === 1'b0) begin
      mon_t = cyc;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_b[i] = tx_serial;
      end
      repeat (16) @(negedge clk);
      chk("tx_stop", tx_serial, 1'b1);
      got_q.push_back(mon_b);
      got_t.push_back(mon_t);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (16) @(negedge clk);
    end
    rx_serial = 1'b1;
    stop_cyc = cyc;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i]);
    ref_cyc = stop_cyc;
  endtask

  task automatic nonce_rsp(input logic [31:0] n);
    exp_q = {8'h08, 8'h00, 8'h00, 8'h03, n[31:24], n[23:16], n[15:8], n[7:0]};
  endtask

  // Expected reply and job state derived from the frame bytes alone
  task automatic model_frame();
    int l;
    l = int'(frm[0]);
    if (l == 0) exp_q = {8'h01};
    else if (l < 8 || l > 60) exp_q = {8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    else if (frm[3] == 8'h00 && l == 8)
      exp_q = {8'h10, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
               8'h13, 8'h37, 8'h0D, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    else if (frm[3] == 8'h02 && l == 60) begin
      exp_q = {8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < 4; k++) begin
        e_nmax[8*k +: 8] = frm[8 + k];
        e_nmin[8*k +: 8] = frm[12 + k];
      end
      for (int k = 0; k < 12; k++) e_work[8*k +: 8] = frm[16 + k];
      for (int k = 0; k < 32; k++) e_mid[8*k +: 8] = frm[28 + k];
      e_nw++;
    end else exp_q = {8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic get_rsp(input int n, input int lat);
    int t = 0;
    while (got_q.size() < n && t < n * 160 + 400) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_timeout", t < n * 160 + 400, 1'b1);
    repeat (400) @(negedge clk);
    chk("rsp_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk($sformatf("rsp_byte%0d", i), got_q[i], exp_q[i]);
    if (got_t.size() > 0) chk("rsp_latency", (got_t[0] - ref_cyc) <= lat, 1'b1);
    got_q = {};
    got_t = {};
  endtask

  task automatic check_job();
    chk("nonce_max", nonce_max, e_nmax);
    chk("nonce_min", nonce_min, e_nmin);
    chk("work_data", work_data, e_work);
    chk("midstate", midstate, e_mid);
    chk("new_work_cnt", nw_cnt, e_nw);
    chk("job_at_pulse", {s_nmax, s_nmin, s_work}, {e_nmax, e_nmin, e_work});
    chk("mid_at_pulse", s_mid, e_mid);
  endtask

  task automatic run_cmd();
    model_frame();
    send_frame();
    get_rsp(exp_q.size(), 15);
    check_job();
  endtask

  task automatic random_nonce();
    logic [31:0] n;
    n = $urandom;
    golden_nonce = n;
    nonce_rsp(n);
    new_golden_nonce = 1'b1;
    ref_cyc = cyc;
    get_rsp(8, 4);
    new_golden_nonce = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int pushes, kind, t;
    logic [31:0] n;
    pushes = 0;
    repeat (4) @(negedge clk);
    chk("rst_tx", tx_serial, 1'b1);
    chk("rst_new_work", new_work, 1'b0);
    chk("rst_job", {work_data, nonce_min, nonce_max, midstate}, '0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_tx", tx_serial, 1'b1);

    frm = {8'h00};
    run_cmd();
    frm = {8'h08, 8'h00, 8'h00, 8'h00, 8'hF9, 8'hEA, 8'h98, 8'h0A};
    run_cmd();
    frm = {8'h06};
    run_cmd();

    frm = {8'h3C, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
    for (int b = 8'h08; b <= 8'h33; b++) frm.push_back(8'(b));
    run_cmd();
    chk("push_nonce_max", nonce_max, 32'h0);
    chk("push_nonce_min", nonce_min, 32'h1FFFFFFF);
    chk("push_work", work_data, 96'h131211100F0E0D0C0B0A0908);
    chk("push_mid", midstate, 256'h333231302F2E2D2C2B2A292827262524232221201F1E1D1C1B1A191817161514);

    golden_nonce = 32'h38B9B05A;
    exp_q = {8'h08, 8'h00, 8'h00, 8'h03, 8'h38, 8'hB9, 8'hB0, 8'h5A};
    new_golden_nonce = 1'b1;
    ref_cyc = cyc;
    get_rsp(8, 4);
    repeat (400) @(negedge clk);
    chk("nonce_once", got_q.size(), 0);
    new_golden_nonce = 1'b0;
    repeat (4) @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      kind = $urandom_range(0, 4);
      if (kind == 0 && pushes >= 2) kind = 1;
      if (kind == 4) random_nonce();
      else begin
        if (kind == 0) begin
          frm = {8'd60, 8'($urandom), 8'($urandom), 8'h02};
          for (int k = 4; k < 60; k++) frm.push_back(8'($urandom));
          pushes++;
        end else if (kind == 1) begin
          frm = {8'd8, 8'($urandom), 8'($urandom), 8'h00};
          for (int k = 4; k < 8; k++) frm.push_back(8'($urandom));
        end else if (kind == 2) begin
          t = $urandom_range(0, 2);
          frm = {t == 0 ? 8'h00 : t == 1 ? 8'($urandom_range(1, 7)) : 8'($urandom_range(61, 255))};
        end else begin
          frm = {8'($urandom_range(8, 20)), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 4))};
          for (int k = 4; k < int'(frm[0]); k++) frm.push_back(8'($urandom));
        end
        run_cmd();
      end
    end

    frm = {8'd8, 8'h00, 8'h00, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    model_frame();
    n = $urandom;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    exp_q.push_back(n[31:24]);
    exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    send_frame();
    t = 0;
    while (got_q.size() < 1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    golden_nonce = n;
    new_golden_nonce = 1'b1;
    @(negedge clk);
    golden_nonce = ~n;
    get_rsp(24, 15);
    new_golden_nonce = 1'b0;
    repeat (4) @(negedge clk);

    frm = {8'd8, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame();
    t = 0;
    while (got_q.size() < 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_timeout", t < 1000, 1'b1);
    repeat (36) @(negedge clk);
    chk("pre_rst_tx_low", tx_serial, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cut_tx", tx_serial, 1'b1);
    chk("rst_cut_new_work", new_work, 1'b0);
    chk("rst_cut_job", {work_data, nonce_min, nonce_max, midstate}, '0);
    reset = 1'b0;
    e_nmax = '0; e_nmin = '0; e_work = '0; e_mid = '0;
    repeat (400) @(negedge clk);
    got_q = {};
    got_t = {};
    frm = {8'h00};
    run_cmd();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
